// File: rtl/rf_write_arbiter_if.sv
// Bundle of WB, MDU, ID-hazard and regfile-port signals around the register file write arbiter.
// master = pipeline/MDU side driving requests, slave = the arbiter itself.
interface rf_write_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_wn;
    logic [31:0] wb_d;
    logic        wb_stall;

    logic        mdu_issue;
    logic [4:0]  mdu_rd;
    logic        mdu_valid;
    logic [4:0]  mdu_wn;
    logic [31:0] mdu_d;
    logic        mdu_ready;

    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        hz_stall;

    logic        rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d;

    modport master (
        output wb_we, wb_wn, wb_d,
        output mdu_issue, mdu_rd, mdu_valid, mdu_wn, mdu_d,
        output id_rs, id_rt,
        input  wb_stall, mdu_ready, hz_stall,
        input  rf_we, rf_wn, rf_d
    );

    modport slave (
        input  wb_we, wb_wn, wb_d,
        input  mdu_issue, mdu_rd, mdu_valid, mdu_wn, mdu_d,
        input  id_rs, id_rt,
        output wb_stall, mdu_ready, hz_stall,
        output rf_we, rf_wn, rf_d
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register file write-port arbiter: WB stage vs. MDU result FIFO, plus MDU destination scoreboard.
// Optional WB-starvation guard enabled by defining RFA_STARVE_GUARD_EN.
module rf_write_arbiter #(
    parameter int DEPTH = 4
`ifdef RFA_STARVE_GUARD_EN
    , parameter int STARVE_MAX = 8
`endif
) (
    input logic clk,
    input logic clrn,
    rf_write_arbiter_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    fifo_wn [DEPTH];
    logic [31:0]   fifo_d  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [31:0]   sb;
    logic [31:0]   sb_set;
    logic [31:0]   sb_clr;
    logic [31:0]   sb_next;

    logic          empty;
    logic          full;
    logic [4:0]    head_wn;
    logic [31:0]   head_d;
    logic          wb_req;
    logic          force_mdu;
    logic          grant_wb;
    logic          grant_mdu;
    logic          mdu_write;
    logic          push;
    logic          pop;

    // Gating the WB request with clrn keeps the regfile port quiet while reset is held.
    always_comb begin
        empty     = (count == '0);
        full      = (count == CW'(DEPTH));
        head_wn   = fifo_wn[rd_ptr];
        head_d    = fifo_d[rd_ptr];
        wb_req    = clrn && bus.wb_we && (bus.wb_wn != 5'd0);
        grant_mdu = !empty && (!wb_req || force_mdu);
        grant_wb  = wb_req && !grant_mdu;
        mdu_write = grant_mdu && (head_wn != 5'd0);
        push      = bus.mdu_valid && !full;
        pop       = grant_mdu;
    end

    always_comb begin
        bus.rf_we = 1'b0;
        bus.rf_wn = 5'd0;
        bus.rf_d  = 32'd0;
        if (grant_wb) begin
            bus.rf_we = 1'b1;
            bus.rf_wn = bus.wb_wn;
            bus.rf_d  = bus.wb_d;
        end else if (mdu_write) begin
            bus.rf_we = 1'b1;
            bus.rf_wn = head_wn;
            bus.rf_d  = head_d;
        end
    end

    assign bus.mdu_ready = !full;

`ifdef RFA_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;

    assign force_mdu    = !empty && (starve_cnt == SW'(STARVE_MAX));
    assign bus.wb_stall = force_mdu;

    // Counts consecutive WB wins over a waiting FIFO head; any MDU grant or an empty FIFO restarts it.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            starve_cnt <= '0;
        end else if (empty || grant_mdu) begin
            starve_cnt <= '0;
        end else if (grant_wb) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end
`else
    assign force_mdu    = 1'b0;
    assign bus.wb_stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wn[wr_ptr] <= bus.mdu_wn;
            fifo_d[wr_ptr]  <= bus.mdu_d;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Set is applied after clear so a same-edge reissue to the retiring register stays pending.
    always_comb begin
        sb_set = 32'd0;
        sb_clr = 32'd0;
        if (bus.mdu_issue && (bus.mdu_rd != 5'd0)) begin
            sb_set = 32'd1 << bus.mdu_rd;
        end
        if (mdu_write) begin
            sb_clr = 32'd1 << head_wn;
        end
        sb_next = ((sb & ~sb_clr) | sb_set) & ~32'd1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sb <= 32'd0;
        end else begin
            sb <= sb_next;
        end
    end

    assign bus.hz_stall = ((bus.id_rs != 5'd0) && sb[bus.id_rs]) ||
                          ((bus.id_rt != 5'd0) && sb[bus.id_rt]);

endmodule
